// File: rtl/jk_pkg.sv
// Shared definitions for the JK-cell modulo counter: mode encoding and
// the JK excitation function that steers a cell from q toward target t.
package jk_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } jk_mode_t;

    // Returns {J,K}; never produces J=K=1, so cells only set, reset or hold.
    function automatic logic [1:0] jk_excite(input logic q, input logic t);
        return {~q & t, q & ~t};
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-low reset and registered
// complementary outputs.
module jk_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    logic q_next;

    assign q_next = (j & ~q) | (~k & q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q  <= RST_VAL;
            qn <= ~RST_VAL;
        end else begin
            q  <= q_next;
            qn <= ~q_next;
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down/load counter built from a bank of JK cells, with
// registered terminal-count and out-of-range-load flags.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MODULUS     = 10,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             load_err
);

    if (WIDTH < 2) begin : g_bad_width
        $fatal(1, "jk_mod_counter: WIDTH must be at least 2");
    end
    if (MODULUS < 2 || longint'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_mod
        $fatal(1, "jk_mod_counter: MODULUS must lie in 2..2**WIDTH");
    end
    if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_rst
        $fatal(1, "jk_mod_counter: RESET_VALUE must be below MODULUS");
    end

    localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);

    logic [WIDTH:0]   q_x;
    logic [WIDTH:0]   inc;
    logic [WIDTH:0]   dec;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             tc_next;
    logic             err_next;
    logic             illegal;

    assign q_x     = {1'b0, q};
    assign inc     = q_x + 1'b1;
    assign dec     = q_x - 1'b1;
    assign illegal = (q_x >= MOD_X);

    // Widened arithmetic: the carry/borrow bit flags the wrap before truncation.
    always_comb begin
        target   = q;
        tc_next  = 1'b0;
        err_next = 1'b0;
        if (en) begin
            case (jk_mode_t'(mode))
                MODE_UP: begin
                    if (illegal) begin
                        target = '0;
                    end else if (inc == MOD_X) begin
                        target  = '0;
                        tc_next = 1'b1;
                    end else begin
                        target = inc[WIDTH-1:0];
                    end
                end
                MODE_DOWN: begin
                    if (illegal) begin
                        target = '0;
                    end else if (dec[WIDTH]) begin
                        target  = MAX_Q;
                        tc_next = 1'b1;
                    end else begin
                        target = dec[WIDTH-1:0];
                    end
                end
                MODE_LOAD: begin
                    if ({1'b0, load_val} < MOD_X) begin
                        target = load_val;
                    end else begin
                        target   = MAX_Q;
                        err_next = 1'b1;
                    end
                end
                default: target = q;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign {j[i], k[i]} = jk_excite(q[i], target[i]);

        jk_cell #(
            .RST_VAL (RST_Q[i])
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j[i]),
            .k     (k[i]),
            .q     (q[i]),
            .qn    (qn[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tc       <= tc_next;
            load_err <= err_next;
        end
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter (WIDTH=4, MODULUS=10): a vector table
// on the default instance plus a mid-count reset sequence on a RESET_VALUE=3 copy.
module tb_jk_mod_counter;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [1:0] mode;
        logic [3:0] load_val;
        logic [3:0] exp_q;
        logic       exp_tc;
        logic       exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_n3 = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] load_val = 4'd0;
    logic [3:0] q, qn, q3, qn3;
    logic       tc, load_err, tc3, load_err3;

    int tests = 0;
    int fails = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load_val(load_val),
        .q(q), .qn(qn), .tc(tc), .load_err(load_err)
    );

    jk_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(3)) dut3 (
        .clk(clk), .rst_n(rst_n3), .en(en), .mode(mode), .load_val(load_val),
        .q(q3), .qn(qn3), .tc(tc3), .load_err(load_err3)
    );

    task automatic add(input logic r, input logic e, input logic [1:0] m,
                       input logic [3:0] lv, input logic [3:0] eq,
                       input logic et, input logic ee);
        vec_t v;
        v.rst_n = r; v.en = e; v.mode = m; v.load_val = lv;
        v.exp_q = eq; v.exp_tc = et; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] got,
                       input logic [3:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, got, want);
        end
    endtask

    // Drive inputs away from the edge, then sample 1 time unit after it.
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [3:0] lv);
        rst_n = r; en = e; mode = m; load_val = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held two cycles while asking to count up
        add(0, 1, 2'b01, 4'd0, 4'd0, 0, 0);
        add(0, 1, 2'b01, 4'd0, 4'd0, 0, 0);
        // up wrap: 1..9, 0 (tc), 1, 2
        for (int i = 1; i <= 12; i++)
            add(1, 1, 2'b01, 4'd0, 4'((i % 10)), (i == 10), 0);
        // back to 0, then down wrap
        add(1, 1, 2'b11, 4'd0, 4'd0, 0, 0);
        add(1, 1, 2'b10, 4'd0, 4'd9, 1, 0);
        add(1, 1, 2'b10, 4'd0, 4'd8, 0, 0);
        add(1, 1, 2'b10, 4'd0, 4'd7, 0, 0);
        // loads, clamping, and load-then-up wrap
        add(1, 1, 2'b11, 4'd6,  4'd6, 0, 0);
        add(1, 1, 2'b11, 4'd12, 4'd9, 0, 1);
        add(1, 1, 2'b11, 4'd9,  4'd9, 0, 0);
        add(1, 1, 2'b01, 4'd0,  4'd0, 1, 0);
        add(1, 1, 2'b11, 4'd10, 4'd9, 0, 1);
        add(1, 1, 2'b11, 4'd15, 4'd9, 0, 1);
        // direction change with no idle cycle: down wraps from 0 again
        add(1, 1, 2'b01, 4'd0,  4'd0, 1, 0);
        add(1, 1, 2'b10, 4'd0,  4'd9, 1, 0);
        add(1, 1, 2'b10, 4'd0,  4'd8, 0, 0);
        // enable low and hold mode at 5
        add(1, 1, 2'b11, 4'd5, 4'd5, 0, 0);
        add(1, 0, 2'b01, 4'd0, 4'd5, 0, 0);
        add(1, 0, 2'b01, 4'd0, 4'd5, 0, 0);
        add(1, 0, 2'b01, 4'd0, 4'd5, 0, 0);
        add(1, 0, 2'b11, 4'd2, 4'd5, 0, 0);
        add(1, 1, 2'b00, 4'd0, 4'd5, 0, 0);
        add(1, 1, 2'b00, 4'd0, 4'd5, 0, 0);
        // reset mid-count on the default instance
        add(1, 1, 2'b01, 4'd0, 4'd6, 0, 0);
        add(0, 1, 2'b01, 4'd0, 4'd0, 0, 0);
        add(1, 1, 2'b01, 4'd0, 4'd1, 0, 0);

        #2;
        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].en, vecs[i].mode, vecs[i].load_val);
            chk("q",        i, q,  vecs[i].exp_q);
            chk("qn",       i, qn, ~vecs[i].exp_q);
            chk("tc",       i, {3'b0, tc},       {3'b0, vecs[i].exp_tc});
            chk("load_err", i, {3'b0, load_err}, {3'b0, vecs[i].exp_err});
        end

        // RESET_VALUE=3 instance: reset, load 7, reset mid-count, resume
        rst_n3 = 1'b0;
        step(1, 1, 2'b01, 4'd0);
        chk("r3_reset_q",  0, q3,  4'd3);
        chk("r3_reset_qn", 0, qn3, 4'hC);
        rst_n3 = 1'b1;
        step(1, 1, 2'b11, 4'd7);
        chk("r3_load_q", 1, q3, 4'd7);
        rst_n3 = 1'b0;
        step(1, 1, 2'b01, 4'd0);
        chk("r3_mid_q",  2, q3,  4'd3);
        chk("r3_mid_qn", 2, qn3, 4'hC);
        chk("r3_mid_tc", 2, {3'b0, tc3}, 4'd0);
        rst_n3 = 1'b1;
        step(1, 1, 2'b01, 4'd0);
        chk("r3_resume1", 3, q3, 4'd4);
        step(1, 1, 2'b01, 4'd0);
        chk("r3_resume2", 4, q3, 4'd5);
        chk("r3_err",     4, {3'b0, load_err3}, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
